echo_delay_engine: RTL and testbench
====================================

Name: echo_delay_engine

Overview:
- Audio-path echo processor directly downstream of the echo control stage.
- Consumes that stage's delay_time, delay_volume and disabled outputs.
- Per input sample: reads the delayed sample from an on-chip circular buffer, scales it by the volume, adds it to the dry sample with saturation, and writes the result back into the buffer (feedback echo).
- Sits between the codec receive path and the codec transmit path.

Parameters:
- DATA_W, 24, signed sample width.
- ADDR_W, 16, buffer address width; DEPTH = 2**ADDR_W samples.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  one-cycle strobe, new dry sample.
- in_sample  input  DATA_W  signed dry sample.
- in_ready  output  1  high only in IDLE; sample accepted on in_valid & in_ready.
- delay_time  input  32  delay in samples.
- delay_volume  input  32  echo gain, 0..128 = 0..1.0.
- disabled  input  1  1 = bypass (no echo).
- out_valid  output  1  one-cycle strobe, out_sample updated.
- out_sample  output  DATA_W  signed processed sample.
- busy  output  1  high while the buffer is being cleared.

Behaviour:
- One clock domain: CLK. Reset is asynchronous and active-high on RST.
- Reset values: state=CLEAR, clr_addr=0, wr_ptr=0, out_valid=0, out_sample=0, in_ready=0, busy=1.
- Buffer: DEPTH x DATA_W single-port RAM, synchronous read (1-cycle), one access per cycle.
- FSM states: CLEAR, IDLE, READ, MAC, WRITE.
- CLEAR:
  - Writes 0 to mem[clr_addr] and increments clr_addr each cycle.
  - After writing DEPTH-1: busy<=0, go to IDLE.
  - Lasts exactly DEPTH cycles after reset release.
- IDLE:
  - in_ready=1.
  - On in_valid: latch x=in_sample, D=clamp(delay_time), V=clamp(delay_volume), byp=disabled; go to READ.
  - Controls are sampled only at acceptance; changes mid-sample have no effect.
- Clamps:
  - D = 1 if delay_time==0; D = DEPTH-1 if delay_time>DEPTH-1; else delay_time[ADDR_W-1:0].
  - V = 128 if delay_volume>128; else delay_volume[7:0].
- READ: issue read at rd_addr = (wr_ptr - D) mod DEPTH; go to MAC.
- MAC:
  - p = d*V, signed, DATA_W+9 bits, V zero-extended.
  - s = x + (p >>> 7), DATA_W+2 bits.
  - y = s saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Go to WRITE.
- WRITE:
  - w = byp ? x : y.
  - mem[wr_ptr]<=w; out_sample<=w; out_valid<=1 for one cycle.
  - wr_ptr<=wr_ptr+1, wrapping DEPTH-1 -> 0.
  - Go to IDLE.
- Latency: out_valid is high in the 4th cycle after the accepting edge; one sample in flight at most.
- in_valid while in_ready=0 (CLEAR, READ, MAC, WRITE): sample dropped, no out_valid, wr_ptr unchanged.
- Bypass: the buffer is still written (with x) so re-enabling replays only real recent input.
- RST mid-operation: immediate return to reset values; any in-flight sample is discarded, no out_valid; CLEAR restarts from address 0.
- out_sample holds its value between out_valid strobes.

Test Plan (ADDR_W=4, DEPTH=16, DATA_W=24 unless noted):
1. Release RST -> busy=1 and in_ready=0 for exactly 16 cycles, then busy=0, in_ready=1, out_sample=0; in_valid during CLEAR produces no out_valid.
2. Impulse: delay_time=4, delay_volume=64, disabled=0; inputs 1000 then zeros -> outputs 1000,0,0,0,500,0,0,0,250,0,0,0,125; each out_valid exactly 3 cycles after acceptance.
3. Bypass: same stimulus with disabled=1 -> 1000 then all zeros. Then set disabled=0 and feed zeros -> no echo of the earlier 1000 once it is older than D.
4. Saturation: delay_time=1, delay_volume=128, constant input 8388607 -> second and later outputs clamp at 8388607. Constant -8388608 -> clamp at -8388608.
5. Clamps:
   - delay_time=0 -> echo after 1 sample.
   - delay_time=1000 -> echo after 15 samples.
   - delay_volume=200 -> behaves as 128 (impulse 1000 -> echo 1000).
6. Robustness:
   - Assert RST while in MAC -> no out_valid; full 16-cycle CLEAR reruns; next impulse echoes from a zeroed buffer.
   - Back-to-back in_valid on consecutive cycles -> only the first is accepted.

Source files
------------

// File: rtl/echo_delay_engine.sv
// echo_delay_engine: feedback echo processor on a circular sample buffer.
// Each accepted dry sample is mixed with a scaled, delayed copy of the
// buffer. The mixed (or bypassed) result is written back into the buffer
// and presented on out_sample.
module echo_delay_engine #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_sample,
    output logic                     in_ready,
    input  logic [31:0]              delay_time,
    input  logic [31:0]              delay_volume,
    input  logic                     disabled,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     busy
);

    localparam int          DEPTH     = 2 ** ADDR_W;
    localparam logic [31:0] MAX_DELAY = 32'(DEPTH - 1);
    localparam logic [31:0] MAX_VOL   = 32'd128;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_READ,
        ST_MAC,
        ST_WRITE
    } state_t;

    state_t                     state_q;
    logic [ADDR_W-1:0]          clr_addr_q;
    logic [ADDR_W-1:0]          wr_ptr_q;
    logic signed [DATA_W-1:0]   x_q;
    logic [ADDR_W-1:0]          d_q;
    logic [7:0]                 v_q;
    logic                       byp_q;
    logic signed [DATA_W-1:0]   y_q;
    logic                       out_valid_q;
    logic signed [DATA_W-1:0]   out_sample_q;
    logic                       in_ready_q;
    logic                       busy_q;

    // Sample buffer and its single shared port.
    logic signed [DATA_W-1:0]   mem [DEPTH];
    logic signed [DATA_W-1:0]   rd_data_q;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic signed [DATA_W-1:0]   mem_wdata;

    // Clamped controls for the sample being accepted.
    logic [ADDR_W-1:0]          d_d;
    logic [7:0]                 v_d;

    // Echo arithmetic.
    logic signed [DATA_W+8:0]   prod;
    logic signed [DATA_W+1:0]   sum;
    logic signed [DATA_W-1:0]   y_d;
    logic signed [DATA_W-1:0]   w_d;

    // Clamp delay to 1..DEPTH-1 and volume to 0..128 at acceptance.
    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        d_d = delay_time[ADDR_W-1:0];
        v_d = delay_volume[7:0];
        if (delay_time == 32'd0) begin
            d_d = ADDR_W'(1);
        end else if (delay_time > MAX_DELAY) begin
            d_d = {ADDR_W{1'b1}};
        end
        if (delay_volume > MAX_VOL) begin
            v_d = 8'd128;
        end
    end

    // Scale the delayed sample by V/128, add the dry sample and saturate.
    always_comb begin
        prod = rd_data_q * $signed({1'b0, v_q});
        sum  = (DATA_W+2)'(x_q) + (DATA_W+2)'(prod >>> 7);
        y_d  = sum[DATA_W-1:0];
        if (sum[DATA_W+1:DATA_W-1] != 3'b000 && sum[DATA_W+1:DATA_W-1] != 3'b111) begin
            y_d = sum[DATA_W+1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                : {1'b0, {(DATA_W-1){1'b1}}};
        end
        w_d = byp_q ? x_q : y_q;
    end

    // Route the single RAM port: clear writes, echo read, result write.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_ptr_q - d_q;
        mem_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_addr_q;
                mem_wdata = '0;
            end
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = wr_ptr_q;
                mem_wdata = w_d;
            end
            default: ;
        endcase
    end

    // Synchronous single-port RAM with one-cycle read latency.
    // NOTE: the buffer has no reset; the CLEAR state zeroes it instead.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_data_q <= mem[mem_addr];
    end

    // Control FSM with registered handshake and output strobes.
    // NOTE: state registers use non-blocking assignments so all updates land together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            wr_ptr_q     <= '0;
            x_q          <= '0;
            d_q          <= ADDR_W'(1);
            v_q          <= '0;
            byp_q        <= 1'b0;
            y_q          <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == {ADDR_W{1'b1}}) begin
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q        <= in_sample;
                        d_q        <= d_d;
                        v_q        <= v_d;
                        byp_q      <= disabled;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_READ;
                    end
                end
                ST_READ: begin
                    state_q <= ST_MAC;
                end
                ST_MAC: begin
                    y_q     <= y_d;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    out_sample_q <= w_d;
                    out_valid_q  <= 1'b1;
                    wr_ptr_q     <= wr_ptr_q + 1'b1;
                    in_ready_q   <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_echo_delay_engine.sv
// Testbench for echo_delay_engine: scoreboard fed by a buffer-level model.
module tb_echo_delay_engine;

    localparam int DW    = 24;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int SMAX  = 8388607;
    localparam int SMIN  = -8388608;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_sample = '0;
    logic                 in_ready;
    logic [31:0]          delay_time = 32'd4;
    logic [31:0]          delay_volume = 32'd64;
    logic                 disabled = 1'b0;
    logic                 out_valid;
    logic signed [DW-1:0] out_sample;
    logic                 busy;

    echo_delay_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_sample    (in_sample),
        .in_ready     (in_ready),
        .delay_time   (delay_time),
        .delay_volume (delay_volume),
        .disabled     (disabled),
        .out_valid    (out_valid),
        .out_sample   (out_sample),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   last_out = 0;

    // Reference model: history of written samples and the write index.
    int hist[DEPTH];
    int wp = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) hist[i] = 0;
        wp = 0;
    endfunction

    // Echo rule: y = sat(x + floor(delayed * V / 128)); bypass passes x.
    function automatic int model_step(input int x, input logic [31:0] dt,
                                      input logic [31:0] dv, input logic dis);
        int     d;
        int     v;
        longint p;
        longint s;
        int     w;
        d = (dt == 0) ? 1 : (dt > DEPTH - 1) ? DEPTH - 1 : int'(dt);
        v = (dv > 128) ? 128 : int'(dv);
        p = longint'(hist[(wp - d + DEPTH) % DEPTH]) * v;
        s = longint'(x) + (p >>> 7);
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        w = dis ? x : int'(s);
        hist[wp] = w;
        wp = (wp + 1) % DEPTH;
        return w;
    endfunction

    function automatic void push_exp(input int x, input logic [31:0] dt,
                                     input logic [31:0] dv, input logic dis);
        exp_t e;
        e.val = model_step(x, dt, dv, dis);
        e.cyc = cyc;
        exp_q.push_back(e);
    endfunction

    // Monitor: every out_valid pops one expected sample and checks value and latency.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_sample", out_sample, e.val);
                    check("latency", cyc - e.cyc, 3);
                    last_out = e.val;
                end
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        ok = in_ready;
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    // Offer one sample; controls are scrambled right after acceptance.
    task automatic send(input int x, input logic [31:0] dt,
                        input logic [31:0] dv, input logic dis);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        in_sample    = x[DW-1:0];
        delay_time   = dt;
        delay_volume = dv;
        disabled     = dis;
        in_valid     = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        push_exp(x, dt, dv, dis);
        delay_time   = $urandom;
        delay_volume = $urandom;
        disabled     = ~dis;
        in_sample    = DW'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        check("out_hold", out_sample, last_out);
    endtask

    // Reset, then verify the CLEAR window; optionally poke in_valid during it.
    task automatic do_reset(input bit poke);
        int n = 0;
        RST      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        model_clear();
        last_out = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", busy, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sample", out_sample, 0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy && !in_ready) n++;
            in_sample = DW'(31337);
            in_valid  = poke && (i < 10);
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        check("clear_cycles", n, DEPTH);
        check("clear_done_busy", busy, 0);
        check("clear_done_ready", in_ready, 1);
        check("clear_done_out", out_sample, 0);
    endtask

    // Accept a sample, then hit RST while it sits in MAC.
    task automatic abort_in_mac();
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        in_sample    = DW'(777);
        delay_time   = 32'd4;
        delay_volume = 32'd64;
        disabled     = 1'b0;
        in_valid     = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        do_reset(1'b0);
    endtask

    // Two consecutive in_valid cycles: the second falls on in_ready=0.
    task automatic back_to_back();
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        delay_time   = 32'd4;
        delay_volume = 32'd64;
        disabled     = 1'b0;
        in_sample    = DW'(1234);
        in_valid     = 1'b1;
        @(posedge CLK);
        #1;
        push_exp(1234, 32'd4, 32'd64, 1'b0);
        in_sample = DW'(4321);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] r;
        model_clear();

        // Reset and CLEAR window, with in_valid poked during CLEAR.
        do_reset(1'b1);

        // Impulse through a half-volume echo at delay 4.
        send(1000, 32'd4, 32'd64, 1'b0);
        repeat (12) send(0, 32'd4, 32'd64, 1'b0);
        drain();

        // Bypass, then re-enable after the impulse has aged out.
        do_reset(1'b0);
        send(1000, 32'd4, 32'd64, 1'b1);
        repeat (7) send(0, 32'd4, 32'd64, 1'b1);
        repeat (8) send(0, 32'd4, 32'd64, 1'b0);
        drain();

        // Saturation at both rails.
        repeat (4) send(SMAX, 32'd1, 32'd128, 1'b0);
        repeat (4) send(SMIN, 32'd1, 32'd128, 1'b0);
        drain();

        // Delay clamp at zero.
        do_reset(1'b0);
        send(1000, 32'd0, 32'd128, 1'b0);
        repeat (2) send(0, 32'd0, 32'd128, 1'b0);
        drain();

        // Delay clamp above DEPTH-1.
        do_reset(1'b0);
        send(1000, 32'd1000, 32'd64, 1'b0);
        repeat (16) send(0, 32'd1000, 32'd64, 1'b0);
        drain();

        // Volume clamp above 128.
        do_reset(1'b0);
        send(1000, 32'd4, 32'd200, 1'b0);
        repeat (4) send(0, 32'd4, 32'd200, 1'b0);
        drain();

        // Reset during MAC, then an impulse into the freshly cleared buffer.
        abort_in_mac();
        send(1000, 32'd4, 32'd64, 1'b0);
        repeat (4) send(0, 32'd4, 32'd64, 1'b0);
        drain();

        // Back-to-back in_valid.
        back_to_back();
        drain();

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            r = DW'($urandom);
            send(int'($signed(r)), 32'($urandom_range(0, 20)),
                 32'($urandom_range(0, 200)), 1'($urandom_range(0, 3) == 0));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
